keccak_byte_packer: RTL and testbench

KECCAK_BYTE_PACKER -- requirements
Module: keccak_byte_packer

---
 rtl/keccak_pkg.sv | 14 +
 rtl/keccak_byte_packer_if.sv | 25 ++
 rtl/keccak_byte_accum.sv | 33 +++
 rtl/keccak_byte_packer.sv | 122 ++++++++++++
 tb/tb_keccak_byte_packer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak byte packer: FSM state encoding and word geometry.
package keccak_pkg;

  localparam int WORD_BYTES = 8;
  localparam int WORD_BITS  = 8 * WORD_BYTES;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    SEND       = 2'd1,
    SEND_EMPTY = 2'd2,
    DONE       = 2'd3
  } state_t;

endpackage

// File: rtl/keccak_byte_packer_if.sv
// Byte-stream input and word-output signals between a message source, the packer and the hash core.
interface keccak_byte_packer_if;
  import keccak_pkg::*;

  logic [7:0]           s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [WORD_BITS-1:0] in;
  logic                 in_ready;
  logic                 is_last;
  logic [2:0]           byte_num;
  logic                 buffer_full;

  modport master (
    output s_data, s_valid, s_last, buffer_full,
    input  s_ready, in, in_ready, is_last, byte_num
  );

  modport slave (
    input  s_data, s_valid, s_last, buffer_full,
    output s_ready, in, in_ready, is_last, byte_num
  );

endinterface

// File: rtl/keccak_byte_accum.sv
// Byte shift register with a left-justify mux so partial words start at the top byte.
module keccak_byte_accum
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [7:0]           data,
  input  logic [2:0]           num,
  output logic [WORD_BITS-1:0] word
);

  logic [WORD_BITS-1:0] acc;
  logic [2:0]           pad_bytes;
  logic [5:0]           shift;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (shift_en) begin
      acc <= {acc[WORD_BITS-9:0], data};
    end
  end

  // num counts valid bytes with 0 meaning a full word, so 8-num wraps to a zero shift.
  always_comb begin
    pad_bytes = 3'd0 - num;
    shift     = {pad_bytes, 3'b000};
    word      = acc << shift;
  end

endmodule

// File: rtl/keccak_byte_packer.sv
// Packs a byte stream into 64-bit words for the Keccak core, one message per reset.
// Optional macro KECCAK_PACKER_MSG_LEN_EN adds the msg_len byte counter output.
module keccak_byte_packer
  import keccak_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  keccak_byte_packer_if.slave bus
`ifdef KECCAK_PACKER_MSG_LEN_EN
  ,
  output logic [63:0]        msg_len
`endif
);

  state_t               state;
  logic [2:0]           cnt;
  logic [2:0]           pend_num;
  logic                 pend_last;
  logic                 need_empty;
  logic                 accept;
  logic                 acc_clear;
  logic [WORD_BITS-1:0] word;

  assign accept    = (state == FILL) && bus.s_valid;
  assign acc_clear = (state == SEND) && !bus.buffer_full;

  keccak_byte_accum u_accum (
    .clk      (clk),
    .reset    (reset),
    .clear    (acc_clear),
    .shift_en (accept),
    .data     (bus.s_data),
    .num      (pend_last ? pend_num : 3'd0),
    .word     (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FILL;
      cnt          <= 3'd0;
      pend_num     <= 3'd0;
      pend_last    <= 1'b0;
      need_empty   <= 1'b0;
      bus.s_ready  <= 1'b1;
      bus.in       <= '0;
      bus.in_ready <= 1'b0;
      bus.is_last  <= 1'b0;
      bus.byte_num <= 3'd0;
    end else begin
      bus.in_ready <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            cnt <= cnt + 3'd1;
            if (bus.s_last) begin
              state       <= SEND;
              bus.s_ready <= 1'b0;
              // A last byte that completes the word still owes the core an empty final word.
              if (cnt == 3'(WORD_BYTES - 1)) begin
                pend_last  <= 1'b0;
                pend_num   <= 3'd0;
                need_empty <= 1'b1;
              end else begin
                pend_last <= 1'b1;
                pend_num  <= cnt + 3'd1;
              end
            end else if (cnt == 3'(WORD_BYTES - 1)) begin
              state       <= SEND;
              bus.s_ready <= 1'b0;
              pend_last   <= 1'b0;
              pend_num    <= 3'd0;
            end
          end
        end
        SEND: begin
          if (!bus.buffer_full) begin
            bus.in       <= word;
            bus.in_ready <= 1'b1;
            bus.is_last  <= pend_last;
            bus.byte_num <= pend_last ? pend_num : 3'd0;
            cnt          <= 3'd0;
            if (pend_last) begin
              state <= DONE;
            end else if (need_empty) begin
              state <= SEND_EMPTY;
            end else begin
              state       <= FILL;
              bus.s_ready <= 1'b1;
            end
          end
        end
        SEND_EMPTY: begin
          if (!bus.buffer_full) begin
            bus.in       <= '0;
            bus.in_ready <= 1'b1;
            bus.is_last  <= 1'b1;
            bus.byte_num <= 3'd0;
            need_empty   <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.s_ready <= 1'b0;
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef KECCAK_PACKER_MSG_LEN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_len <= '0;
    end else if (accept && (msg_len != '1)) begin
      msg_len <= msg_len + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Directed self-checking bench for keccak_byte_packer; covers msg_len when KECCAK_PACKER_MSG_LEN_EN is defined.
module tb_keccak_byte_packer;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  num;
  } strobe_t;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  int      checks = 0;
  int      passed = 0;
  strobe_t strobes[$];

  keccak_byte_packer_if bus();

`ifdef KECCAK_PACKER_MSG_LEN_EN
  logic [63:0] msg_len;
  keccak_byte_packer dut (.clk(clk), .reset(reset), .bus(bus), .msg_len(msg_len));
`else
  keccak_byte_packer dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Record every word strobe half a cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.in_ready === 1'b1) strobes.push_back({bus.in, bus.is_last, bus.byte_num});
  end

  function automatic strobe_t get_strobe(input int idx);
    if (idx < strobes.size()) return strobes[idx];
    return '1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.buffer_full = 1'b0;
    strobes.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int guard = 0;
    bus.s_data = d;
    bus.s_valid = 1'b1;
    bus.s_last = last;
    while (bus.s_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      $display("[TB] FAIL send_timeout: s_ready stayed %0b, required 1", bus.s_ready);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    int guard = 0;
    while (strobes.size() < n && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (strobes.size() < n) $display("[TB] FAIL strobe_count: got %0d strobes, required %0d", strobes.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.s_ready !== 1'b1) $display("[TB] FAIL reset_s_ready: got %0b required 1", bus.s_ready); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %0b required 0", bus.in_ready); else passed++;
    checks++; if (bus.in !== 64'd0) $display("[TB] FAIL reset_in: got %h required 0", bus.in); else passed++;
    checks++; if (bus.is_last !== 1'b0) $display("[TB] FAIL reset_is_last: got %0b required 0", bus.is_last); else passed++;
    checks++; if (bus.byte_num !== 3'd0) $display("[TB] FAIL reset_byte_num: got %0d required 0", bus.byte_num); else passed++;
  endtask

  task automatic test_full_word();
    strobe_t s;
    do_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    wait_strobes(2);
    s = get_strobe(0);
    checks++; if (s.data !== 64'h0102030405060708) $display("[TB] FAIL full_word0_in: got %h required 0102030405060708", s.data); else passed++;
    checks++; if (s.last !== 1'b0 || s.num !== 3'd0) $display("[TB] FAIL full_word0_flags: got last=%0b num=%0d required last=0 num=0", s.last, s.num); else passed++;
    s = get_strobe(1);
    checks++; if (s.data !== 64'd0) $display("[TB] FAIL full_empty_in: got %h required 0", s.data); else passed++;
    checks++; if (s.last !== 1'b1 || s.num !== 3'd0) $display("[TB] FAIL full_empty_flags: got last=%0b num=%0d required last=1 num=0", s.last, s.num); else passed++;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (strobes.size() != 2) $display("[TB] FAIL full_extra_strobes: got %0d required 2", strobes.size()); else passed++;
    checks++; if (bus.s_ready !== 1'b0) $display("[TB] FAIL full_done_s_ready: got %0b required 0", bus.s_ready); else passed++;
  endtask

  task automatic test_partial();
    do_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL partial_latency: in_ready got %0b required 1", bus.in_ready); else passed++;
    checks++; if (bus.in !== 64'hAABBCC0000000000) $display("[TB] FAIL partial_in: got %h required aabbcc0000000000", bus.in); else passed++;
    checks++; if (bus.is_last !== 1'b1 || bus.byte_num !== 3'd3) $display("[TB] FAIL partial_flags: got last=%0b num=%0d required last=1 num=3", bus.is_last, bus.byte_num); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL partial_one_cycle: in_ready got %0b required 0", bus.in_ready); else passed++;
    checks++; if (bus.in !== 64'hAABBCC0000000000 || bus.byte_num !== 3'd3) $display("[TB] FAIL partial_hold: got %h num=%0d required aabbcc0000000000 num=3", bus.in, bus.byte_num); else passed++;
    checks++; if (bus.s_ready !== 1'b0) $display("[TB] FAIL partial_done_s_ready: got %0b required 0", bus.s_ready); else passed++;
    send_done_probe();
  endtask

  // A byte offered in DONE must not be accepted nor produce a strobe.
  task automatic send_done_probe();
    bus.s_data = 8'h77;
    bus.s_valid = 1'b1;
    bus.s_last = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    checks++; if (strobes.size() != 1 || bus.s_ready !== 1'b0) $display("[TB] FAIL done_idle: strobes=%0d s_ready=%0b required 1 and 0", strobes.size(), bus.s_ready); else passed++;
  endtask

  task automatic test_multi_word();
    strobe_t s;
    do_reset();
    for (int i = 0; i <= 10; i++) send_byte(8'(i), i == 10);
    wait_strobes(2);
    s = get_strobe(0);
    checks++; if (s.data !== 64'h0001020304050607 || s.last !== 1'b0) $display("[TB] FAIL multi_word0: got %h last=%0b required 0001020304050607 last=0", s.data, s.last); else passed++;
    s = get_strobe(1);
    checks++; if (s.data !== 64'h08090A0000000000) $display("[TB] FAIL multi_word1_in: got %h required 08090a0000000000", s.data); else passed++;
    checks++; if (s.last !== 1'b1 || s.num !== 3'd3) $display("[TB] FAIL multi_word1_flags: got last=%0b num=%0d required last=1 num=3", s.last, s.num); else passed++;
`ifdef KECCAK_PACKER_MSG_LEN_EN
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (msg_len !== 64'd11) $display("[TB] FAIL multi_msg_len: got %0d required 11", msg_len); else passed++;
`endif
  endtask

  task automatic test_backpressure();
    int bad_ready = 0;
    do_reset();
    bus.buffer_full = 1'b1;
    send_byte(8'h5A, 1'b0);
    send_byte(8'h5B, 1'b0);
    send_byte(8'h5C, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.in_ready !== 1'b0 || bus.s_ready !== 1'b0) bad_ready++;
    end
    checks++; if (bad_ready != 0 || strobes.size() != 0) $display("[TB] FAIL bp_hold: bad cycles=%0d strobes=%0d required 0 and 0", bad_ready, strobes.size()); else passed++;
    bus.buffer_full = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL bp_release: in_ready got %0b required 1", bus.in_ready); else passed++;
    checks++; if (bus.in !== 64'h5A5B5C0000000000 || bus.byte_num !== 3'd3) $display("[TB] FAIL bp_word: got %h num=%0d required 5a5b5c0000000000 num=3", bus.in, bus.byte_num); else passed++;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (strobes.size() != 1) $display("[TB] FAIL bp_single: got %0d strobes required 1", strobes.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    strobe_t s;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'hE1 + 8'(i), 1'b0);
    do_reset();
    send_byte(8'h11, 1'b1);
    wait_strobes(1);
    s = get_strobe(0);
    checks++; if (s.data !== 64'h1100000000000000) $display("[TB] FAIL mid_reset_in: got %h required 1100000000000000", s.data); else passed++;
    checks++; if (s.last !== 1'b1 || s.num !== 3'd1) $display("[TB] FAIL mid_reset_flags: got last=%0b num=%0d required last=1 num=1", s.last, s.num); else passed++;
    // Park a full word in SEND behind backpressure, then reset it away.
    do_reset();
    bus.buffer_full = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    do_reset();
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (strobes.size() != 0 || bus.s_ready !== 1'b1) $display("[TB] FAIL send_reset_discard: strobes=%0d s_ready=%0b required 0 and 1", strobes.size(), bus.s_ready); else passed++;
  endtask

  initial begin
    bus.s_data = 8'd0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.buffer_full = 1'b0;
    test_reset();
    test_full_word();
    test_partial();
    test_multi_word();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
